// File: rtl/memex_lsu_if.sv
// Data-memory bus between the MEMEX load/store unit (master) and data memory (slave).
interface memex_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/memex_lsu.sv
// MEMEX-stage load/store unit: issues one data-memory access per load/store,
// steers store byte lanes, formats load data and stalls the pipeline meanwhile.
module memex_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        invalid_MEMEX,
    input  logic        mem_read_MEMEX,
    input  logic        mem_write_MEMEX,
    input  logic [31:0] alu_result_MEMEX,
    input  logic [1:0]  data_width_MEMEX,
    input  logic        lsu_sign_extend_MEMEX,
    input  logic [31:0] store_data_MEMEX,
    memex_lsu_if.master bus,
    output logic [31:0] load_data_MEMEX,
    output logic        stall_MEMEX,
    output logic        misaligned_MEMEX,
    output logic        bus_error_MEMEX
);
    localparam int NUM_LANES = 4;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        rd_q;
    logic        sext_q;
    logic [1:0]  width_q;
    logic [1:0]  lo_q;

    logic [1:0]  a;
    logic        op;
    logic        bad_align;
    logic        start;
    logic        timeout_hit;

    assign a           = alu_result_MEMEX[1:0];
    assign op          = !invalid_MEMEX & (mem_read_MEMEX | mem_write_MEMEX);
    assign bad_align   = (data_width_MEMEX == 2'b11)
                       | ((data_width_MEMEX == 2'b01) & a[0])
                       | ((data_width_MEMEX == 2'b10) & (a != 2'b00));
    assign start       = (state == IDLE) & op & !bad_align;
    assign misaligned_MEMEX = (state == IDLE) & op & bad_align;
    // Stall rises in the issuing IDLE cycle so the instruction is held for BUSY.
    assign stall_MEMEX = start | (state == BUSY);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == T_LAST);

    // Store lane steering; strobes are zero for loads.
    logic [NUM_LANES-1:0]      wstrb_n;
    logic [NUM_LANES-1:0][7:0] wdata_n;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wstrb_n[i] = mem_write_MEMEX &
            ((data_width_MEMEX == 2'b00) ? (a == 2'(i)) :
             (data_width_MEMEX == 2'b01) ? (a[1] == 1'(i / 2)) : 1'b1);
        assign wdata_n[i] = !mem_write_MEMEX ? 8'h00 :
            (data_width_MEMEX == 2'b00) ? store_data_MEMEX[7:0] :
            (data_width_MEMEX == 2'b01) ? store_data_MEMEX[8*(i%2) +: 8] :
                                          store_data_MEMEX[8*i +: 8];
    end

    // Load formatting works from the fields captured at issue.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        ld_byte = bus.dmem_rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        ld_fmt  = bus.dmem_rdata;
        case (width_q)
            2'b00:   ld_fmt = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_fmt = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rd_q            <= 1'b0;
            sext_q          <= 1'b0;
            width_q         <= 2'b00;
            lo_q            <= 2'b00;
            bus.dmem_req    <= 1'b0;
            bus.dmem_we     <= 1'b0;
            bus.dmem_addr   <= 32'h0;
            bus.dmem_wstrb  <= 4'h0;
            bus.dmem_wdata  <= 32'h0;
            load_data_MEMEX <= 32'h0;
            bus_error_MEMEX <= 1'b0;
        end else begin
            bus_error_MEMEX <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= BUSY;
                        cnt            <= '0;
                        rd_q           <= mem_read_MEMEX;
                        sext_q         <= lsu_sign_extend_MEMEX;
                        width_q        <= data_width_MEMEX;
                        lo_q           <= a;
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= mem_write_MEMEX;
                        bus.dmem_addr  <= {alu_result_MEMEX[31:2], 2'b00};
                        bus.dmem_wstrb <= wstrb_n;
                        bus.dmem_wdata <= wdata_n;
                    end else if (misaligned_MEMEX) begin
                        load_data_MEMEX <= 32'h0;
                    end
                end
                BUSY: begin
                    if (bus.dmem_ready) begin
                        state        <= DONE;
                        bus.dmem_req <= 1'b0;
                        bus.dmem_we  <= 1'b0;
                        if (rd_q)
                            load_data_MEMEX <= ld_fmt;
                    end else if (timeout_hit) begin
                        state           <= DONE;
                        bus.dmem_req    <= 1'b0;
                        bus.dmem_we     <= 1'b0;
                        bus_error_MEMEX <= 1'b1;
                        load_data_MEMEX <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
